// File: rtl/axi_lite_regfile_pkg.sv
// Shared constants, FSM state types and address decode helper for the
// AXI4-Lite register file.
package axi_lite_regfile_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_COLLECT = 1'b0,
        W_RESP    = 1'b1
    } w_state_t;

    typedef enum logic {
        R_IDLE  = 1'b0,
        R_VALID = 1'b1
    } r_state_t;

    // Word index of a byte address; the sub-word byte offset is dropped.
    function automatic logic [31:0] addr_to_index(input logic [31:0] addr,
                                                  input int unsigned addr_lsb);
        return addr >> addr_lsb;
    endfunction

endpackage

// File: rtl/axi_lite_regfile_if.sv
// AXI4-Lite bus bundle between the PS/BFM master and the register file.
// Handshake rule for every channel: a transfer happens on a rising ACLK
// edge where both VALID and READY are high; VALID and its payload stay
// stable until that edge, and VALID never waits on READY.
interface axi_lite_regfile_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic [2:0]              S_AXI_AWPROT;
    logic                    S_AXI_AWVALID;
    logic                    S_AXI_AWREADY;
    logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                    S_AXI_WVALID;
    logic                    S_AXI_WREADY;
    logic [1:0]              S_AXI_BRESP;
    logic                    S_AXI_BVALID;
    logic                    S_AXI_BREADY;
    logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic [2:0]              S_AXI_ARPROT;
    logic                    S_AXI_ARVALID;
    logic                    S_AXI_ARREADY;
    logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]              S_AXI_RRESP;
    logic                    S_AXI_RVALID;
    logic                    S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );
endinterface

// File: rtl/axi_lite_regfile_byte_merge.sv
// Next-value merge for one register: bus-strobed bytes win, otherwise the
// hardware update port, otherwise the register keeps its old byte.
module axi_lite_regfile_byte_merge #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]   i_old,
    input  logic                    i_bus_we,
    input  logic [DATA_WIDTH-1:0]   i_bus_data,
    input  logic [DATA_WIDTH/8-1:0] i_bus_strb,
    input  logic                    i_hw_we,
    input  logic [DATA_WIDTH-1:0]   i_hw_data,
    output logic [DATA_WIDTH-1:0]   o_new
);
    // Per-byte priority select: bus strobe, then hardware, then hold.
    always_comb begin
        o_new = i_old;
        for (int b = 0; b < DATA_WIDTH/8; b++) begin
            if (i_bus_we && i_bus_strb[b]) begin
                o_new[b*8 +: 8] = i_bus_data[b*8 +: 8];
            end else if (i_hw_we) begin
                o_new[b*8 +: 8] = i_hw_data[b*8 +: 8];
            end
        end
    end
endmodule

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave register file with byte strobes, SLVERR decode and a
// per-register hardware update port. Write and read paths run independently.
module axi_lite_regfile
    import axi_lite_regfile_pkg::*;
#(
    parameter int                    NUM_REGS    = 4,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    axi_lite_regfile_if.slave              s_axi,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            reg_wr_pulse,
    input  logic [NUM_REGS-1:0]            hw_we,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_wdata,
    output w_state_t                       o_dbg_w_state,
    output r_state_t                       o_dbg_r_state
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int ADDR_LSB   = $clog2(STRB_WIDTH);

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] w_reg_next [NUM_REGS];

    w_state_t              r_w_state;
    logic                  r_awready, r_wready, r_aw_held, r_w_held;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_WIDTH-1:0] r_wstrb;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic [NUM_REGS-1:0]   r_wr_pulse;

    r_state_t              r_r_state;
    logic                  r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;

    logic                  w_aw_hs, w_w_hs, w_commit, w_cmt_valid;
    logic [ADDR_WIDTH-1:0] w_cmt_addr;
    logic [DATA_WIDTH-1:0] w_cmt_data;
    logic [STRB_WIDTH-1:0] w_cmt_strb;
    logic [31:0]           w_cmt_idx, w_ar_idx;
    logic [NUM_REGS-1:0]   w_bus_we;
    logic                  w_ar_valid;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_unused;

    // PROT fields carry no meaning for this block.
    assign w_unused = &{1'b0, s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT};

    // READY registers are only high in W_COLLECT, so a handshake implies that state.
    assign w_aw_hs    = s_axi.S_AXI_AWVALID & r_awready;
    assign w_w_hs     = s_axi.S_AXI_WVALID & r_wready;
    assign w_commit   = (r_w_state == W_COLLECT) & (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);
    assign w_cmt_addr = r_aw_held ? r_awaddr : s_axi.S_AXI_AWADDR;
    assign w_cmt_data = r_w_held ? r_wdata : s_axi.S_AXI_WDATA;
    assign w_cmt_strb = r_w_held ? r_wstrb : s_axi.S_AXI_WSTRB;
    assign w_cmt_idx  = addr_to_index(32'(w_cmt_addr), ADDR_LSB);
    assign w_cmt_valid = (w_cmt_idx < 32'(NUM_REGS));

    assign w_ar_idx   = addr_to_index(32'(s_axi.S_AXI_ARADDR), ADDR_LSB);
    assign w_ar_valid = (w_ar_idx < 32'(NUM_REGS));

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            assign w_bus_we[gi] = w_commit & (w_cmt_idx == 32'(gi));
            assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH] = r_regs[gi];

            axi_lite_regfile_byte_merge #(.DATA_WIDTH(DATA_WIDTH)) u_merge (
                .i_old      (r_regs[gi]),
                .i_bus_we   (w_bus_we[gi]),
                .i_bus_data (w_cmt_data),
                .i_bus_strb (w_cmt_strb),
                .i_hw_we    (hw_we[gi]),
                .i_hw_data  (hw_wdata[gi*DATA_WIDTH +: DATA_WIDTH]),
                .o_new      (w_reg_next[gi])
            );
        end
    endgenerate

    // Read mux; out-of-range indices select nothing and read as zero.
    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_ar_idx == 32'(i)) begin
                w_rd_data = r_regs[i];
            end
        end
    end

    // Register storage: merged bus/hardware next values every cycle.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VALUE;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= w_reg_next[i];
        end
    end

    // Write FSM: collect AW and W in any order, commit, then hold B until taken.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_w_state  <= W_COLLECT;
            r_awready  <= 1'b1;
            r_wready   <= 1'b1;
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_awaddr   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= '0;
            case (r_w_state)
                W_COLLECT: begin
                    if (w_commit) begin
                        r_awready  <= 1'b0;
                        r_wready   <= 1'b0;
                        r_aw_held  <= 1'b0;
                        r_w_held   <= 1'b0;
                        r_bvalid   <= 1'b1;
                        r_bresp    <= w_cmt_valid ? RESP_OKAY : RESP_SLVERR;
                        r_wr_pulse <= w_bus_we;
                        r_w_state  <= W_RESP;
                    end else begin
                        if (w_aw_hs) begin
                            r_awready <= 1'b0;
                            r_aw_held <= 1'b1;
                            r_awaddr  <= s_axi.S_AXI_AWADDR;
                        end
                        if (w_w_hs) begin
                            r_wready <= 1'b0;
                            r_w_held <= 1'b1;
                            r_wdata  <= s_axi.S_AXI_WDATA;
                            r_wstrb  <= s_axi.S_AXI_WSTRB;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi.S_AXI_BREADY) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                        r_w_state <= W_COLLECT;
                    end
                end
                default: r_w_state <= W_COLLECT;
            endcase
        end
    end

    // Read FSM: capture data on AR handshake, hold R until taken.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_r_state <= R_IDLE;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
        end else begin
            case (r_r_state)
                R_IDLE: begin
                    if (s_axi.S_AXI_ARVALID) begin
                        r_rdata   <= w_ar_valid ? w_rd_data : '0;
                        r_rresp   <= w_ar_valid ? RESP_OKAY : RESP_SLVERR;
                        r_rvalid  <= 1'b1;
                        r_r_state <= R_VALID;
                    end
                end
                R_VALID: begin
                    if (s_axi.S_AXI_RREADY) begin
                        r_rvalid  <= 1'b0;
                        r_r_state <= R_IDLE;
                    end
                end
                default: r_r_state <= R_IDLE;
            endcase
        end
    end

    assign s_axi.S_AXI_AWREADY = r_awready;
    assign s_axi.S_AXI_WREADY  = r_wready;
    assign s_axi.S_AXI_BVALID  = r_bvalid;
    assign s_axi.S_AXI_BRESP   = r_bresp;
    assign s_axi.S_AXI_ARREADY = (r_r_state == R_IDLE);
    assign s_axi.S_AXI_RVALID  = r_rvalid;
    assign s_axi.S_AXI_RDATA   = r_rdata;
    assign s_axi.S_AXI_RRESP   = r_rresp;
    assign reg_wr_pulse        = r_wr_pulse;
    assign o_dbg_w_state       = r_w_state;
    assign o_dbg_r_state       = r_r_state;

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed bench for axi_lite_regfile (4 x 32-bit registers, 8-bit address).
module tb_axi_lite_regfile;
    import axi_lite_regfile_pkg::*;

    logic         clk;
    logic         rst;
    logic [127:0] reg_q;
    logic [3:0]   reg_wr_pulse;
    logic [3:0]   hw_we;
    logic [127:0] hw_wdata;
    w_state_t     dbg_w;
    r_state_t     dbg_r;

    int total = 0;
    int bad   = 0;

    logic [1:0]  resp;
    logic [3:0]  pulse;
    logic [31:0] rdata;

    axi_lite_regfile_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

    axi_lite_regfile #(
        .NUM_REGS(4), .DATA_WIDTH(32), .ADDR_WIDTH(8), .RESET_VALUE(32'h0)
    ) dut (
        .ACLK          (clk),
        .ARESET        (rst),
        .s_axi         (bus.slave),
        .reg_q         (reg_q),
        .reg_wr_pulse  (reg_wr_pulse),
        .hw_we         (hw_we),
        .hw_wdata      (hw_wdata),
        .o_dbg_w_state (dbg_w),
        .o_dbg_r_state (dbg_r)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                             input logic [3:0] strb,
                             output logic [1:0] o_resp, output logic [3:0] o_pulse);
        logic aw_done, w_done, aw_go, w_go;
        int   n;
        bus.S_AXI_AWADDR  = addr;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA   = data;
        bus.S_AXI_WSTRB   = strb;
        bus.S_AXI_WVALID  = 1'b1;
        aw_done = 1'b0;
        w_done  = 1'b0;
        n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            aw_go = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
            w_go  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
            @(posedge clk); #1;
            if (aw_go) begin aw_done = 1'b1; bus.S_AXI_AWVALID = 1'b0; end
            if (w_go)  begin w_done  = 1'b1; bus.S_AXI_WVALID  = 1'b0; end
            n++;
        end
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        if (!(aw_done && w_done)) check("wr_hs_timeout", {126'b0, aw_done, w_done}, 128'd3);
        n = 0;
        while (!bus.S_AXI_BVALID && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.S_AXI_BVALID) check("bvalid_timeout", {127'b0, bus.S_AXI_BVALID}, 128'd1);
        o_resp  = bus.S_AXI_BRESP;
        o_pulse = reg_wr_pulse;
        bus.S_AXI_BREADY = 1'b1;
        @(posedge clk); #1;
        bus.S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] addr,
                            output logic [31:0] o_data, output logic [1:0] o_resp);
        logic ar_go, ar_done;
        int   n;
        bus.S_AXI_ARADDR  = addr;
        bus.S_AXI_ARVALID = 1'b1;
        ar_done = 1'b0;
        n = 0;
        while (!ar_done && n < 20) begin
            ar_go = bus.S_AXI_ARREADY;
            @(posedge clk); #1;
            if (ar_go) ar_done = 1'b1;
            n++;
        end
        bus.S_AXI_ARVALID = 1'b0;
        if (!ar_done) check("ar_hs_timeout", {127'b0, ar_done}, 128'd1);
        n = 0;
        while (!bus.S_AXI_RVALID && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.S_AXI_RVALID) check("rvalid_timeout", {127'b0, bus.S_AXI_RVALID}, 128'd1);
        o_data = bus.S_AXI_RDATA;
        o_resp = bus.S_AXI_RRESP;
        bus.S_AXI_RREADY = 1'b1;
        @(posedge clk); #1;
        bus.S_AXI_RREADY = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        hw_we = '0;
        hw_wdata = '0;
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA = '0;  bus.S_AXI_WSTRB = '0;  bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_awready", {127'b0, bus.S_AXI_AWREADY}, 128'd1);
        check("rst_wready",  {127'b0, bus.S_AXI_WREADY}, 128'd1);
        check("rst_arready", {127'b0, bus.S_AXI_ARREADY}, 128'd1);
        check("rst_bvalid",  {127'b0, bus.S_AXI_BVALID}, 128'd0);
        check("rst_rvalid",  {127'b0, bus.S_AXI_RVALID}, 128'd0);
        check("rst_resps",   {124'b0, bus.S_AXI_BRESP, bus.S_AXI_RRESP}, 128'd0);
        check("rst_rdata",   {96'b0, bus.S_AXI_RDATA}, 128'd0);
        check("rst_pulse",   {124'b0, reg_wr_pulse}, 128'd0);
        check("rst_reg_q",   reg_q, 128'd0);

        // Sequential writes then read-back
        for (int i = 0; i < 4; i++) begin
            axi_write(8'(i * 4), 32'(i + 1), 4'hF, resp, pulse);
            check("seq_bresp", {126'b0, resp}, 128'd0);
            check("seq_pulse", {124'b0, pulse}, 128'(4'b0001 << i));
        end
        check("seq_reg_q", reg_q, 128'h00000004_00000003_00000002_00000001);
        for (int i = 0; i < 4; i++) begin
            axi_read(8'(i * 4), rdata, resp);
            check("seq_rdata", {96'b0, rdata}, 128'(i + 1));
            check("seq_rresp", {126'b0, resp}, 128'd0);
        end

        // Byte strobes
        axi_write(8'h04, 32'hAABBCCDD, 4'hF, resp, pulse);
        axi_write(8'h04, 32'h11223344, 4'b0101, resp, pulse);
        check("strb_pulse", {124'b0, pulse}, 128'd2);
        axi_read(8'h04, rdata, resp);
        check("strb_rdata", {96'b0, rdata}, 128'hAA22CC44);

        // W three cycles ahead of AW, then a stalled B channel
        bus.S_AXI_WDATA  = 32'h00000055;
        bus.S_AXI_WSTRB  = 4'hF;
        bus.S_AXI_WVALID = 1'b1;
        @(posedge clk); #1;
        bus.S_AXI_WVALID = 1'b0;
        check("ord_wready_drop", {127'b0, bus.S_AXI_WREADY}, 128'd0);
        check("ord_no_bvalid", {127'b0, bus.S_AXI_BVALID}, 128'd0);
        repeat (2) begin
            @(posedge clk); #1;
            check("ord_wait", {125'b0, bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 128'b010);
        end
        bus.S_AXI_AWADDR  = 8'h08;
        bus.S_AXI_AWVALID = 1'b1;
        @(posedge clk); #1;
        bus.S_AXI_AWVALID = 1'b0;
        check("ord_bvalid", {127'b0, bus.S_AXI_BVALID}, 128'd1);
        check("ord_pulse", {124'b0, reg_wr_pulse}, 128'd4);
        check("ord_state", {127'b0, dbg_w == W_RESP}, 128'd1);
        check("ord_reg_q", reg_q, 128'h00000004_00000055_AA22CC44_00000001);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("ord_hold", {121'b0, bus.S_AXI_BVALID, bus.S_AXI_BRESP,
                  bus.S_AXI_AWREADY, bus.S_AXI_WREADY, reg_wr_pulse[2], 1'b0}, 128'b1000000);
        end
        bus.S_AXI_BREADY = 1'b1;
        @(posedge clk); #1;
        bus.S_AXI_BREADY = 1'b0;
        check("ord_release", {125'b0, bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 128'b011);

        // Out-of-range address
        axi_write(8'h10, 32'h0000DEAD, 4'hF, resp, pulse);
        check("oor_bresp", {126'b0, resp}, 128'd2);
        check("oor_pulse", {124'b0, pulse}, 128'd0);
        check("oor_reg_q", reg_q, 128'h00000004_00000055_AA22CC44_00000001);
        axi_read(8'h10, rdata, resp);
        check("oor_rdata", {96'b0, rdata}, 128'd0);
        check("oor_rresp", {126'b0, resp}, 128'd2);

        // Bus commit, hardware write and read of reg2 in the same cycle
        bus.S_AXI_AWADDR = 8'h08; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA = 32'h0;  bus.S_AXI_WSTRB = 4'b0011; bus.S_AXI_WVALID = 1'b1;
        bus.S_AXI_ARADDR = 8'h08; bus.S_AXI_ARVALID = 1'b1;
        hw_we = 4'b0100;
        hw_wdata = {32'h0, 32'hFFFFFFFF, 64'h0};
        @(posedge clk); #1;
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
        hw_we = '0;
        check("col_reg2", {96'b0, reg_q[95:64]}, 128'hFFFF0000);
        check("col_rdata_old", {96'b0, bus.S_AXI_RDATA}, 128'h00000055);
        check("col_valids", {126'b0, bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 128'b11);
        check("col_pulse", {124'b0, reg_wr_pulse}, 128'd4);
        bus.S_AXI_BREADY = 1'b1; bus.S_AXI_RREADY = 1'b1;
        @(posedge clk); #1;
        bus.S_AXI_BREADY = 1'b0; bus.S_AXI_RREADY = 1'b0;

        // Hardware-only update does not pulse
        hw_we = 4'b1000;
        hw_wdata = {32'h12345678, 96'h0};
        @(posedge clk); #1;
        hw_we = '0;
        check("hw_reg_q", reg_q, 128'h12345678_FFFF0000_AA22CC44_00000001);
        check("hw_no_pulse", {124'b0, reg_wr_pulse}, 128'd0);

        // Reset while a read response is pending
        bus.S_AXI_ARADDR = 8'h04; bus.S_AXI_ARVALID = 1'b1;
        @(posedge clk); #1;
        bus.S_AXI_ARVALID = 1'b0;
        check("rr_rvalid", {127'b0, bus.S_AXI_RVALID}, 128'd1);
        check("rr_rdata", {96'b0, bus.S_AXI_RDATA}, 128'hAA22CC44);
        #2 rst = 1'b1;
        #1;
        check("rr_rvalid_clr", {127'b0, bus.S_AXI_RVALID}, 128'd0);
        check("rr_reg_q", reg_q, 128'd0);
        check("rr_arready", {127'b0, bus.S_AXI_ARREADY}, 128'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("rr_no_rvalid", {126'b0, bus.S_AXI_RVALID, bus.S_AXI_BVALID}, 128'd0);
        axi_read(8'h00, rdata, resp);
        check("rr_read0", {94'b0, resp, rdata}, 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
